// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 widths, FSM states, request record
// and the static legality check applied at accept time.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WRITE, RESP} lsu_state_t;

    typedef struct packed {
        logic        write;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } lsu_req_t;

    // Illegal width code or misalignment; the range check needs MEM_DEPTH and lives in the top.
    function automatic logic req_illegal(input logic write, input logic [2:0] f3,
                                         input logic [31:0] addr);
        logic bad_f3;
        logic misal;
        bad_f3 = write ? (f3 > F3_W)
                       : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        case (f3)
            F3_H, F3_HU: misal = addr[0];
            F3_W:        misal = |addr[1:0];
            default:     misal = 1'b0;
        endcase
        return bad_f3 | misal;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction with sign/zero extension for loads, and byte/halfword merge for stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{byte_off, 3'b000} +: 8];
        lane_h = byte_off[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   load_data = {24'h0, lane_b};
            F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   load_data = {16'h0, lane_h};
            default: load_data = rdata;
        endcase

        merged = rdata;
        case (funct3)
            F3_B: merged[{byte_off, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (byte_off[1]) merged[31:16] = wdata[15:0];
                else             merged[15:0]  = wdata[15:0];
            end
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: single outstanding request, read-modify-write for sub-word stores
// against a combinational-read word memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_DEPTH = 100001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_we
);

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

    lsu_state_t  state, state_nxt;
    lsu_req_t    req_q;
    logic [31:0] merge_q;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        accept;
    logic        acc_err;
    logic        is_sw;

    assign accept  = req_valid && req_ready;
    assign acc_err = req_illegal(req_write, req_funct3, req_addr)
                   || ({2'b00, req_addr[31:2]} >= DEPTH_W);
    assign is_sw   = (req_q.funct3 == F3_W);

    lsu_align u_align (
        .funct3    (req_q.funct3),
        .byte_off  (req_q.addr[1:0]),
        .rdata     (mem_rdata),
        .wdata     (req_q.wdata),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Memory-side outputs decode straight from state so reset silences them immediately.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = 32'h0;
        mem_we     = 1'b0;
        mem_wdata  = 32'h0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = acc_err ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_addr = {2'b00, req_q.addr[31:2]};
                if (req_q.write && is_sw) begin
                    mem_we    = 1'b1;
                    mem_wdata = req_q.wdata;
                    state_nxt = RESP;
                end else if (req_q.write) begin
                    state_nxt = MERGE_WRITE;
                end else begin
                    state_nxt = RESP;
                end
            end
            MERGE_WRITE: begin
                mem_addr  = {2'b00, req_q.addr[31:2]};
                mem_we    = 1'b1;
                mem_wdata = merge_q;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= '0;
            merge_q    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_error <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= '{write: req_write, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                if (acc_err) begin
                    resp_error <= 1'b1;
                    resp_rdata <= 32'h0;
                end
            end
            if (state == ACCESS) begin
                merge_q    <= merged;
                resp_error <= 1'b0;
                resp_rdata <= req_q.write ? 32'h0 : load_data;
            end
        end
    end

endmodule
